// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard receive path: frame FSM
// state encoding, scan-code prefix constants and default timing values.
`timescale 1ns/1ps
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_t;

  localparam logic [7:0] SC_EXT = 8'hE0;
  localparam logic [7:0] SC_BRK = 8'hF0;

  localparam int DEF_FILTER_LEN  = 8;
  localparam int DEF_TIMEOUT_CYC = 50000;

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: pin synchronisers, clock glitch filter, frame FSM
// (start / 8 data LSB first / odd parity / stop), inter-bit timeout and
// registered byte_valid / error pulses.
`timescale 1ns/1ps
module ps2_frame_rx import ps2_pkg::*; #(
  parameter int FILTER_LEN  = DEF_FILTER_LEN,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic       CLOCK_50,
  input  logic       Resetn,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       parity_err,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);

  logic          clk_meta, clk_sync, dat_meta, dat_sync;
  logic          clk_filt;
  logic [FW-1:0] filt_cnt;
  logic          fall;
  rx_state_t     state, next_state;
  logic [2:0]    bit_cnt;
  logic [7:0]    data_sr;
  logic          par_bit;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;
  logic          frame_ok, par_bad, stop_bad;

  // Two-flop synchronisers; idle-high lines so they come out of reset at 1
  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) begin
      clk_meta <= 1'b1;
      clk_sync <= 1'b1;
      dat_meta <= 1'b1;
      dat_sync <= 1'b1;
    end else begin
      clk_meta <= PS2_CLK;
      clk_sync <= clk_meta;
      dat_meta <= PS2_DAT;
      dat_sync <= dat_meta;
    end
  end

  // Filtered clock follows the synchronised clock only after it has
  // disagreed for FILTER_LEN consecutive samples
  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) begin
      clk_filt <= 1'b1;
      filt_cnt <= '0;
    end else if (clk_sync == clk_filt) begin
      filt_cnt <= '0;
    end else if (filt_cnt == FILT_LAST) begin
      clk_filt <= clk_sync;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + FW'(1);
    end
  end

  // Accepted falling edge: the cycle in which the filtered clock drops
  assign fall = clk_filt & ~clk_sync & (filt_cnt == FILT_LAST);

  // Inter-edge watchdog, only armed while a frame is in progress
  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) begin
      tmo_cnt <= '0;
    end else if (state == IDLE || fall || tmo_hit) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

  assign tmo_hit = (state != IDLE) && !fall && (tmo_cnt == TMO_LAST);

  // Frame FSM state register
  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) state <= IDLE;
    else         state <= next_state;
  end

  // Frame FSM next-state logic; a timeout abandons any partial frame
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (fall && !dat_sync)      next_state = DATA;
      DATA:    if (fall && bit_cnt == 3'd7) next_state = PARITY;
      PARITY:  if (fall)                   next_state = STOP;
      STOP:    if (fall)                   next_state = IDLE;
      default:                             next_state = IDLE;
    endcase
    if (tmo_hit) next_state = IDLE;
  end

  // Bit counter, data shift register and parity latch
  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) begin
      bit_cnt <= 3'd0;
      data_sr <= 8'h00;
      par_bit <= 1'b0;
    end else if (fall) begin
      case (state)
        IDLE:   bit_cnt <= 3'd0;
        DATA: begin
          data_sr[bit_cnt] <= dat_sync;
          bit_cnt          <= bit_cnt + 3'd1;
        end
        PARITY: par_bit <= dat_sync;
        default: ;
      endcase
    end
  end

  // Stop-bit verdict: parity is judged first so only one error can fire
  always_comb begin
    frame_ok = 1'b0;
    par_bad  = 1'b0;
    stop_bad = 1'b0;
    if (state == STOP && fall) begin
      if (!(^{data_sr, par_bit})) par_bad  = 1'b1;
      else if (dat_sync)          frame_ok = 1'b1;
      else                        stop_bad = 1'b1;
    end
  end

  // Registered result pulses and the held received byte
  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) begin
      rx_byte    <= 8'h00;
      byte_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= frame_ok;
      parity_err <= par_bad;
      frame_err  <= stop_bad | tmo_hit;
      if (frame_ok) rx_byte <= data_sr;
    end
  end

endmodule

// File: rtl/ps2_scan_rx.sv
// Keyboard receive front end: framed PS/2 byte receiver plus a prefix
// tracker that folds E0/F0 prefixes into a single key event.
`timescale 1ns/1ps
module ps2_scan_rx import ps2_pkg::*; #(
  parameter int FILTER_LEN  = DEF_FILTER_LEN,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic       CLOCK_50,
  input  logic       Resetn,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic [7:0] key_code,
  output logic       key_break,
  output logic       key_ext,
  output logic       key_valid,
  output logic       parity_err,
  output logic       frame_err
);

  logic brk_pend, ext_pend;

  ps2_frame_rx #(
    .FILTER_LEN  (FILTER_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_frame_rx (
    .CLOCK_50   (CLOCK_50),
    .Resetn     (Resetn),
    .PS2_CLK    (PS2_CLK),
    .PS2_DAT    (PS2_DAT),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err)
  );

  // Prefix tracker: prefixes set sticky flags, any other byte closes the
  // event, and a dropped frame forgets any half-built prefix sequence
  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) begin
      brk_pend  <= 1'b0;
      ext_pend  <= 1'b0;
      key_code  <= 8'h00;
      key_break <= 1'b0;
      key_ext   <= 1'b0;
      key_valid <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (parity_err || frame_err) begin
        brk_pend <= 1'b0;
        ext_pend <= 1'b0;
      end else if (byte_valid) begin
        if (rx_byte == SC_EXT) begin
          ext_pend <= 1'b1;
        end else if (rx_byte == SC_BRK) begin
          brk_pend <= 1'b1;
        end else begin
          key_code  <= rx_byte;
          key_break <= brk_pend;
          key_ext   <= ext_pend;
          key_valid <= 1'b1;
          brk_pend  <= 1'b0;
          ext_pend  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_scan_rx.sv
// Self-checking bench for ps2_scan_rx: directed PS/2 frames, a queue-based
// event model of bytes / key events / errors, and a per-cycle compare process.
`timescale 1ns/1ps
module tb_ps2_scan_rx;

  localparam int HALF        = 25;
  localparam int FILTER_LEN  = 8;
  localparam int TIMEOUT_CYC = 50000;

  logic       CLOCK_50 = 1'b0;
  logic       Resetn   = 1'b0;
  logic       PS2_CLK  = 1'b1;
  logic       PS2_DAT  = 1'b1;
  logic [7:0] rx_byte, key_code;
  logic       byte_valid, key_break, key_ext, key_valid, parity_err, frame_err;

  ps2_scan_rx #(
    .FILTER_LEN  (FILTER_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .Resetn     (Resetn),
    .PS2_CLK    (PS2_CLK),
    .PS2_DAT    (PS2_DAT),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .key_code   (key_code),
    .key_break  (key_break),
    .key_ext    (key_ext),
    .key_valid  (key_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  typedef struct packed {
    logic [7:0] code;
    logic       brk;
    logic       ext;
  } key_t;

  int vectors = 0;
  int miscompares = 0;
  int bv_cnt = 0, kv_cnt = 0, pe_cnt = 0, fe_cnt = 0;
  int s_bv, s_kv, s_pe, s_fe;
  int last_fall = 0;

  logic [7:0] exp_bytes[$];
  key_t       exp_keys[$];
  logic [1:0] exp_errs[$];
  logic       m_brk = 1'b0, m_ext = 1'b0;
  logic [7:0] m_rx = 8'h00;
  key_t       m_key = '0;
  logic       bv_d = 1'b0;
  logic [1:0] e_pop;

  // Count one comparison and report it if it does not match
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One PS/2 bit cell: data set while clock high, then clock low, then high
  task automatic ps2Bit(input logic b);
    @(negedge CLOCK_50);
    PS2_DAT = b;
    repeat (HALF) @(negedge CLOCK_50);
    PS2_CLK = 1'b0;
    last_fall = cyc;
    repeat (HALF) @(negedge CLOCK_50);
    PS2_CLK = 1'b1;
  endtask

  // Send nbits of a frame; a full frame also advances the event model
  task automatic applyStimulus(input logic [7:0] data, input logic par_flip,
                               input logic stop_val, input int nbits);
    logic [10:0] fr;
    fr = {stop_val, (~^data) ^ par_flip, data, 1'b0};
    if (nbits == 11) begin
      if (par_flip) begin
        exp_errs.push_back(2'b10);
        m_brk = 1'b0; m_ext = 1'b0;
      end else if (!stop_val) begin
        exp_errs.push_back(2'b01);
        m_brk = 1'b0; m_ext = 1'b0;
      end else begin
        exp_bytes.push_back(data);
        if (data == 8'hE0)      m_ext = 1'b1;
        else if (data == 8'hF0) m_brk = 1'b1;
        else begin
          exp_keys.push_back(key_t'{code: data, brk: m_brk, ext: m_ext});
          m_brk = 1'b0; m_ext = 1'b0;
        end
      end
    end
    for (int i = 0; i < nbits; i++) ps2Bit(fr[i]);
    @(negedge CLOCK_50);
    PS2_DAT = 1'b1;
    repeat (4 * HALF) @(negedge CLOCK_50);
  endtask

  task automatic snap();
    s_bv = bv_cnt; s_kv = kv_cnt; s_pe = pe_cnt; s_fe = fe_cnt;
  endtask

  task automatic checkDelta(input int ebv, input int ekv, input int epe, input int efe);
    checkOutput("byte_valid_count", bv_cnt - s_bv, ebv);
    checkOutput("key_valid_count",  kv_cnt - s_kv, ekv);
    checkOutput("parity_err_count", pe_cnt - s_pe, epe);
    checkOutput("frame_err_count",  fe_cnt - s_fe, efe);
  endtask

  task automatic checkKey(input logic [7:0] code, input logic brk, input logic ext);
    checkOutput("key_code_lit",  32'(key_code),  32'(code));
    checkOutput("key_break_lit", 32'(key_break), 32'(brk));
    checkOutput("key_ext_lit",   32'(key_ext),   32'(ext));
  endtask

  // Compare process: every pulse is matched against the model queues
  always @(negedge CLOCK_50) begin
    if (!Resetn) begin
      m_rx  = 8'h00;
      m_key = '0;
      bv_d  = 1'b0;
    end else begin
      if (byte_valid) begin
        bv_cnt++;
        checkOutput("byte_expected", 32'(exp_bytes.size() != 0), 32'd1);
        if (exp_bytes.size() != 0) begin
          m_rx = exp_bytes.pop_front();
          checkOutput("rx_byte", 32'(rx_byte), 32'(m_rx));
        end
      end
      if (key_valid) begin
        kv_cnt++;
        checkOutput("key_one_after_byte", 32'(bv_d), 32'd1);
        checkOutput("key_expected", 32'(exp_keys.size() != 0), 32'd1);
        if (exp_keys.size() != 0) begin
          m_key = exp_keys.pop_front();
          checkOutput("key_code",  32'(key_code),  32'(m_key.code));
          checkOutput("key_break", 32'(key_break), 32'(m_key.brk));
          checkOutput("key_ext",   32'(key_ext),   32'(m_key.ext));
        end
        checkOutput("rx_hold_at_key", 32'(rx_byte), 32'(m_rx));
      end
      if (parity_err || frame_err) begin
        if (parity_err) pe_cnt++;
        if (frame_err)  fe_cnt++;
        checkOutput("err_expected", 32'(exp_errs.size() != 0), 32'd1);
        if (exp_errs.size() != 0) begin
          e_pop = exp_errs.pop_front();
          checkOutput("err_kind", 32'({parity_err, frame_err}), 32'(e_pop));
        end
        checkOutput("rx_hold_at_err",  32'(rx_byte),  32'(m_rx));
        checkOutput("key_hold_at_err", 32'({key_code, key_break, key_ext}), 32'(m_key));
      end
      bv_d = byte_valid;
    end
  end

  // Directed scenarios
  initial begin
    int dt;
    repeat (5) @(negedge CLOCK_50);
    checkOutput("reset_outputs", 32'({rx_byte, byte_valid, key_code, key_break, key_ext,
                                      key_valid, parity_err, frame_err}), 32'd0);
    Resetn = 1'b1;
    repeat (20) @(negedge CLOCK_50);

    $display("[TB] plain make code 1C");
    snap(); applyStimulus(8'h1C, 1'b0, 1'b1, 11);
    checkDelta(1, 1, 0, 0); checkKey(8'h1C, 1'b0, 1'b0);
    checkOutput("rx_byte_lit", 32'(rx_byte), 32'h1C);

    $display("[TB] break F0 1C");
    snap(); applyStimulus(8'hF0, 1'b0, 1'b1, 11); applyStimulus(8'h1C, 1'b0, 1'b1, 11);
    checkDelta(2, 1, 0, 0); checkKey(8'h1C, 1'b1, 1'b0);

    $display("[TB] extended break E0 F0 75, then 1C");
    snap(); applyStimulus(8'hE0, 1'b0, 1'b1, 11); applyStimulus(8'hF0, 1'b0, 1'b1, 11);
    applyStimulus(8'h75, 1'b0, 1'b1, 11);
    checkDelta(3, 1, 0, 0); checkKey(8'h75, 1'b1, 1'b1);
    applyStimulus(8'h1C, 1'b0, 1'b1, 11);
    checkKey(8'h1C, 1'b0, 1'b0);

    $display("[TB] repeated prefix E0 E0 6B");
    snap(); applyStimulus(8'hE0, 1'b0, 1'b1, 11); applyStimulus(8'hE0, 1'b0, 1'b1, 11);
    applyStimulus(8'h6B, 1'b0, 1'b1, 11);
    checkDelta(3, 1, 0, 0); checkKey(8'h6B, 1'b0, 1'b1);

    $display("[TB] F0, bad parity 1C, then 32");
    snap(); applyStimulus(8'hF0, 1'b0, 1'b1, 11); applyStimulus(8'h1C, 1'b1, 1'b1, 11);
    applyStimulus(8'h32, 1'b0, 1'b1, 11);
    checkDelta(2, 1, 1, 0); checkKey(8'h32, 1'b0, 1'b0);
    checkOutput("rx_byte_lit", 32'(rx_byte), 32'h32);

    $display("[TB] bad stop, and bad parity with bad stop");
    snap(); applyStimulus(8'h44, 1'b0, 1'b0, 11);
    checkDelta(0, 0, 0, 1);
    snap(); applyStimulus(8'h5A, 1'b1, 1'b0, 11);
    checkDelta(0, 0, 1, 0);
    checkOutput("rx_byte_held", 32'(rx_byte), 32'h32);

    $display("[TB] non-prefix special byte AA");
    snap(); applyStimulus(8'hAA, 1'b0, 1'b1, 11);
    checkDelta(1, 1, 0, 0); checkKey(8'hAA, 1'b0, 1'b0);

    $display("[TB] E0 then truncated frame, timeout");
    applyStimulus(8'hE0, 1'b0, 1'b1, 11);
    snap();
    exp_errs.push_back(2'b01);
    m_brk = 1'b0; m_ext = 1'b0;
    applyStimulus(8'h3C, 1'b0, 1'b1, 5);
    for (int i = 0; i < 60000; i++) begin
      if (frame_err) break;
      @(negedge CLOCK_50);
    end
    checkOutput("timeout_seen", 32'(frame_err), 32'd1);
    dt = cyc - last_fall;
    checkOutput("timeout_window", 32'(dt >= TIMEOUT_CYC && dt <= TIMEOUT_CYC + FILTER_LEN + 8), 32'd1);
    repeat (500) @(negedge CLOCK_50);
    checkDelta(0, 0, 0, 1);
    applyStimulus(8'h1C, 1'b0, 1'b1, 11);
    checkKey(8'h1C, 1'b0, 1'b0);

    $display("[TB] reset mid-frame, glitch, then 21");
    applyStimulus(8'hF0, 1'b0, 1'b1, 11);
    applyStimulus(8'h21, 1'b0, 1'b1, 5);
    @(negedge CLOCK_50);
    Resetn = 1'b0;
    m_brk = 1'b0; m_ext = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    for (int i = 0; i < 6; i++) begin
      checkOutput("outputs_in_reset", 32'({rx_byte, byte_valid, key_code, key_break, key_ext,
                                           key_valid, parity_err, frame_err}), 32'd0);
      @(negedge CLOCK_50);
    end
    Resetn = 1'b1;
    repeat (10) @(negedge CLOCK_50);
    snap();
    PS2_DAT = 1'b0;
    PS2_CLK = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    PS2_CLK = 1'b1;
    repeat (40) @(negedge CLOCK_50);
    PS2_DAT = 1'b1;
    repeat (20) @(negedge CLOCK_50);
    checkDelta(0, 0, 0, 0);
    applyStimulus(8'h21, 1'b0, 1'b1, 11);
    checkDelta(1, 1, 0, 0); checkKey(8'h21, 1'b0, 1'b0);

    repeat (50) @(negedge CLOCK_50);
    checkOutput("bytes_drained", exp_bytes.size(), 0);
    checkOutput("keys_drained",  exp_keys.size(),  0);
    checkOutput("errs_drained",  exp_errs.size(),  0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Run-length guard
  initial begin
    repeat (150000) @(posedge CLOCK_50);
    $display("[TB] FAIL watchdog: run did not complete, got cycle %0d, want < 150000", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
